// File: rtl/pl_ex_rns_mc.sv
// Multi-cycle execute stage for the RNS datapath: modular add/sub/mul per residue
// channel plus integer mode in domain 0, with a bit-serial multiplier shared by all domains.
module pl_ex_rns_mc #(
  parameter int NUM_DOMAINS = 2,
  parameter int DATA_WID = 8,
  parameter int MOD_WID = 9,
  parameter logic [NUM_DOMAINS*MOD_WID-1:0] MODULI = {9'd256, 9'd129},
  parameter int PROG_CTR_WID = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [2:0]                      op,
  input  logic                            rns_op,
  input  logic [NUM_DOMAINS*DATA_WID-1:0] op1,
  input  logic [NUM_DOMAINS*DATA_WID-1:0] op2,
  input  logic [3:0]                      dest_addr,
  input  logic [PROG_CTR_WID-1:0]         pc_in,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_DOMAINS*DATA_WID-1:0] result,
  output logic                            cout,
  output logic [3:0]                      dest_addr_out,
  output logic [PROG_CTR_WID-1:0]         pc_out,
  output logic                            busy
);
  localparam int NW = NUM_DOMAINS * DATA_WID;
  localparam int EW = DATA_WID + 1;
  localparam int CW = (DATA_WID > 1) ? $clog2(DATA_WID) : 1;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t                  state_reg;
  logic                    out_valid_reg;
  logic                    busy_reg;
  logic                    cout_reg;
  logic                    mul_rns_reg;
  logic [NW-1:0]           result_reg;
  logic [3:0]              dest_out_reg;
  logic [3:0]              mul_dest_reg;
  logic [PROG_CTR_WID-1:0] pc_out_reg;
  logic [PROG_CTR_WID-1:0] mul_pc_reg;
  logic [CW-1:0]           cnt_reg;
  logic [DATA_WID-1:0]     a_reg   [NUM_DOMAINS];
  logic [DATA_WID-1:0]     b_reg   [NUM_DOMAINS];
  logic [DATA_WID-1:0]     acc_reg [NUM_DOMAINS];
  logic [2*DATA_WID-1:0]   int_acc_reg;

  logic [DATA_WID-1:0]     a_red    [NUM_DOMAINS];
  logic [DATA_WID-1:0]     b_red    [NUM_DOMAINS];
  logic [DATA_WID-1:0]     rns_add  [NUM_DOMAINS];
  logic [DATA_WID-1:0]     rns_sub  [NUM_DOMAINS];
  logic [DATA_WID-1:0]     acc_step [NUM_DOMAINS];

  logic                    accept;
  logic [DATA_WID:0]       int_sum;
  logic [DATA_WID:0]       int_dif;
  logic [2*DATA_WID-1:0]   int_acc_step;
  logic [NW-1:0]           sc_result;
  logic                    sc_cout;
  logic [NW-1:0]           mul_result;
  logic                    mul_cout;

  assign in_ready = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Per-domain modular arithmetic; every intermediate stays below 2m, so EW bits suffice.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
      localparam logic [EW-1:0] M = EW'(MODULI[gi*MOD_WID +: MOD_WID]);
      logic [EW-1:0] a_ext;
      logic [EW-1:0] b_ext;
      logic [EW-1:0] ar;
      logic [EW-1:0] br;
      logic [EW-1:0] sum;
      logic [EW-1:0] dbl;
      logic [EW-1:0] dbl_m;
      logic [EW-1:0] inc;
      logic          bit_sel;

      assign a_ext = EW'(op1[gi*DATA_WID +: DATA_WID]);
      assign b_ext = EW'(op2[gi*DATA_WID +: DATA_WID]);
      assign ar    = (a_ext >= M) ? a_ext - M : a_ext;
      assign br    = (b_ext >= M) ? b_ext - M : b_ext;
      assign sum   = ar + br;

      assign a_red[gi]   = ar[DATA_WID-1:0];
      assign b_red[gi]   = br[DATA_WID-1:0];
      assign rns_add[gi] = (sum >= M) ? DATA_WID'(sum - M) : sum[DATA_WID-1:0];
      assign rns_sub[gi] = (ar >= br) ? DATA_WID'(ar - br) : DATA_WID'(ar + M - br);

      // One Horner step: acc = 2*acc mod m, then conditionally add a mod m.
      assign bit_sel = b_reg[gi][cnt_reg];
      assign dbl     = {acc_reg[gi], 1'b0};
      assign dbl_m   = (dbl >= M) ? dbl - M : dbl;
      assign inc     = dbl_m + EW'(a_reg[gi]);
      assign acc_step[gi] = bit_sel ? ((inc >= M) ? DATA_WID'(inc - M) : inc[DATA_WID-1:0])
                                    : dbl_m[DATA_WID-1:0];
    end
  endgenerate

  assign int_sum = {1'b0, op1[DATA_WID-1:0]} + {1'b0, op2[DATA_WID-1:0]};
  assign int_dif = {1'b0, op1[DATA_WID-1:0]} - {1'b0, op2[DATA_WID-1:0]};
  assign int_acc_step = (int_acc_reg << 1)
                      + (b_reg[0][cnt_reg] ? (2*DATA_WID)'(a_reg[0]) : '0);

  always_comb begin
    sc_result = '0;
    sc_cout   = 1'b0;
    case (op)
      OP_ADD: begin
        if (rns_op) begin
          for (int i = 0; i < NUM_DOMAINS; i++) sc_result[i*DATA_WID +: DATA_WID] = rns_add[i];
        end else begin
          sc_result[DATA_WID-1:0] = int_sum[DATA_WID-1:0];
          sc_cout                 = int_sum[DATA_WID];
        end
      end
      OP_SUB: begin
        if (rns_op) begin
          for (int i = 0; i < NUM_DOMAINS; i++) sc_result[i*DATA_WID +: DATA_WID] = rns_sub[i];
        end else begin
          sc_result[DATA_WID-1:0] = int_dif[DATA_WID-1:0];
          sc_cout                 = int_dif[DATA_WID];
        end
      end
      default: sc_result = op1;
    endcase
  end

  always_comb begin
    mul_result = '0;
    mul_cout   = 1'b0;
    if (mul_rns_reg) begin
      for (int i = 0; i < NUM_DOMAINS; i++) mul_result[i*DATA_WID +: DATA_WID] = acc_step[i];
    end else begin
      mul_result[DATA_WID-1:0] = int_acc_step[DATA_WID-1:0];
      mul_cout                 = |int_acc_step[2*DATA_WID-1:DATA_WID];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      cout_reg      <= 1'b0;
      result_reg    <= '0;
      dest_out_reg  <= '0;
      pc_out_reg    <= '0;
      cnt_reg       <= '0;
      mul_rns_reg   <= 1'b0;
      mul_dest_reg  <= '0;
      mul_pc_reg    <= '0;
      int_acc_reg   <= '0;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        a_reg[i]   <= '0;
        b_reg[i]   <= '0;
        acc_reg[i] <= '0;
      end
    end else if (flush) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state_reg    <= ST_BUSY;
              busy_reg     <= 1'b1;
              cnt_reg      <= CW'(DATA_WID - 1);
              mul_rns_reg  <= rns_op;
              mul_dest_reg <= dest_addr;
              mul_pc_reg   <= pc_in;
              int_acc_reg  <= '0;
              for (int i = 0; i < NUM_DOMAINS; i++) begin
                a_reg[i]   <= rns_op ? a_red[i] : op1[i*DATA_WID +: DATA_WID];
                b_reg[i]   <= rns_op ? b_red[i] : op2[i*DATA_WID +: DATA_WID];
                acc_reg[i] <= '0;
              end
            end else begin
              result_reg    <= sc_result;
              cout_reg      <= sc_cout;
              dest_out_reg  <= dest_addr;
              pc_out_reg    <= pc_in;
              out_valid_reg <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          for (int i = 0; i < NUM_DOMAINS; i++) acc_reg[i] <= acc_step[i];
          int_acc_reg <= int_acc_step;
          cnt_reg     <= cnt_reg - CW'(1);
          // Last bit: publish the step value directly rather than waiting a cycle.
          if (cnt_reg == '0) begin
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
            result_reg    <= mul_result;
            cout_reg      <= mul_cout;
            dest_out_reg  <= mul_dest_reg;
            pc_out_reg    <= mul_pc_reg;
            out_valid_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  assign out_valid     = out_valid_reg;
  assign result        = result_reg;
  assign cout          = cout_reg;
  assign dest_addr_out = dest_out_reg;
  assign pc_out        = pc_out_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_pl_ex_rns_mc.sv
// Directed bench for pl_ex_rns_mc: an arithmetic/timing reference model checked every
// cycle, plus hand-computed expectations for the key vectors.
module tb_pl_ex_rns_mc;
  localparam int ND = 2;
  localparam int DW = 8;
  localparam int NW = ND * DW;
  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic          rns_op;
  logic [NW-1:0] op1;
  logic [NW-1:0] op2;
  logic [3:0]    dest_addr;
  logic [PW-1:0] pc_in;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] result;
  logic          cout;
  logic [3:0]    dest_addr_out;
  logic [PW-1:0] pc_out;
  logic          busy;

  pl_ex_rns_mc dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rns_op(rns_op), .op1(op1), .op2(op2), .dest_addr(dest_addr),
    .pc_in(pc_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .dest_addr_out(dest_addr_out), .pc_out(pc_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  bit            started = 1'b0;
  bit            m_valid = 1'b0;
  bit            m_zero = 1'b0;
  int            m_left = 0;
  logic [NW:0]   m_val = '0;
  logic [3:0]    m_dest = '0;
  logic [PW-1:0] m_pc = '0;
  logic [NW:0]   pend_val = '0;
  logic [3:0]    pend_dest = '0;
  logic [PW-1:0] pend_pc = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Returns {cout, result} from plain modular/integer arithmetic.
  function automatic logic [NW:0] calc(input logic [2:0] f_op, input logic f_rns,
                                       input logic [NW-1:0] f_a, input logic [NW-1:0] f_b);
    logic [NW-1:0] r;
    logic          c;
    int            av, bv, m, x;
    r = '0;
    c = 1'b0;
    x = 0;
    if (f_op >= 3'd3) return {1'b0, f_a};
    if (f_rns) begin
      for (int d = 0; d < ND; d++) begin
        m  = (d == 0) ? 129 : 256;
        av = int'(f_a[d*DW +: DW]) % m;
        bv = int'(f_b[d*DW +: DW]) % m;
        case (f_op)
          3'd0:    x = (av + bv) % m;
          3'd1:    x = (av - bv + m) % m;
          default: x = (av * bv) % m;
        endcase
        r[d*DW +: DW] = x[DW-1:0];
      end
    end else begin
      av = int'(f_a[DW-1:0]);
      bv = int'(f_b[DW-1:0]);
      case (f_op)
        3'd0:    begin x = av + bv;            c = (x >= (1 << DW)); end
        3'd1:    begin x = av - bv + (1 << DW); c = (av < bv);       end
        default: begin x = av * bv;            c = (x >= (1 << DW)); end
      endcase
      r[DW-1:0] = x[DW-1:0];
    end
    return {c, r};
  endfunction

  // Model update on each rising edge, from the bench's own driven inputs.
  always @(posedge clk) begin
    bit rdy;
    cyc++;
    if (!reset) begin
      started = 1'b1;
      m_valid = 1'b0;
      m_zero  = 1'b1;
      m_left  = 0;
      m_val   = '0;
      m_dest  = '0;
      m_pc    = '0;
    end else if (started) begin
      if (flush) begin
        m_valid = 1'b0;
        m_left  = 0;
      end else begin
        rdy = (m_left == 0) && (!m_valid || out_ready);
        if (m_valid && out_ready) m_valid = 1'b0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_valid = 1'b1;
            m_val   = pend_val;
            m_dest  = pend_dest;
            m_pc    = pend_pc;
          end
        end else if (in_valid && rdy) begin
          m_zero = 1'b0;
          if (op == 3'd2) begin
            m_left    = DW;
            pend_val  = calc(op, rns_op, op1, op2);
            pend_dest = dest_addr;
            pend_pc   = pc_in;
          end else begin
            m_valid = 1'b1;
            m_val   = calc(op, rns_op, op1, op2);
            m_dest  = dest_addr;
            m_pc    = pc_in;
          end
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'((m_left == 0) && (!m_valid || out_ready) && !flush));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_left > 0));
      if (m_valid || m_zero) begin
        chk("result", 32'(result), 32'(m_val[NW-1:0]));
        chk("cout", 32'(cout), 32'(m_val[NW]));
        chk("dest_addr_out", 32'(dest_addr_out), 32'(m_dest));
        chk("pc_out", 32'(pc_out), 32'(m_pc));
      end
    end
  end

  task automatic send(input logic [2:0] t_op, input logic t_rns, input logic [NW-1:0] t_a,
                      input logic [NW-1:0] t_b, input logic [3:0] t_d, input logic [PW-1:0] t_pc);
    bit got;
    in_valid  = 1'b1;
    op        = t_op;
    rns_op    = t_rns;
    op1       = t_a;
    op2       = t_b;
    dest_addr = t_d;
    pc_in     = t_pc;
    got       = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (got) begin
      @(posedge clk);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output int bcyc);
    bit got;
    bcyc = 0;
    got  = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else if (busy) bcyc++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: out_valid stayed 0, expected 1 within 40 cycles");
    end
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int vc;
    int c0;
    reset = 1'b0; in_valid = 1'b0; op = 3'd0; rns_op = 1'b0; op1 = '0; op2 = '0;
    dest_addr = '0; pc_in = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Pin the reference model to hand-computed values
    chk("model_rns_add", 32'(calc(3'd0, 1'b1, 16'hC864, 16'h6432)), 32'h02C15);
    chk("model_rns_sub", 32'(calc(3'd1, 1'b1, 16'h0032, 16'h0064)), 32'h0004F);
    chk("model_rns_mul", 32'(calc(3'd2, 1'b1, 16'hC864, 16'h6432)), 32'h02062);
    chk("model_rns_red", 32'(calc(3'd2, 1'b1, 16'h0082, 16'h0002)), 32'h00002);
    chk("model_int_add", 32'(calc(3'd0, 1'b0, 16'h00C8, 16'h0064)), 32'h1002C);
    chk("model_int_sub", 32'(calc(3'd1, 1'b0, 16'h0005, 16'h0007)), 32'h100FE);
    chk("model_int_mul", 32'(calc(3'd2, 1'b0, 16'h0010, 16'h0010)), 32'h10000);

    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_result", 32'(result), 32'd0);

    send(3'd0, 1'b1, 16'hC864, 16'h6432, 4'd3, 10'd10);
    @(negedge clk);
    chk("rns_add_lit", 32'(result), 32'h2C15);
    chk("rns_add_valid", 32'(out_valid), 32'd1);

    send(3'd1, 1'b1, 16'h0032, 16'h0064, 4'd4, 10'd11);
    @(negedge clk);
    chk("rns_sub_lit", 32'(result), 32'h004F);

    send(3'd2, 1'b1, 16'hC864, 16'h6432, 4'd5, 10'd12);
    wait_result(bc);
    chk("mul_busy_cycles", 32'(bc), 32'd8);
    chk("rns_mul_lit", 32'(result), 32'h2062);
    chk("rns_mul_tag", 32'(dest_addr_out), 32'd5);

    send(3'd2, 1'b1, 16'h0082, 16'h0002, 4'd6, 10'd13);
    wait_result(bc);
    chk("rns_mul_red_lit", 32'(result), 32'h0002);

    send(3'd0, 1'b0, 16'h00C8, 16'h0064, 4'd7, 10'd14);
    @(negedge clk);
    chk("int_add_lit", 32'(result), 32'h002C);
    chk("int_add_cout", 32'(cout), 32'd1);

    send(3'd1, 1'b0, 16'h0005, 16'h0007, 4'd8, 10'd15);
    send(3'd2, 1'b0, 16'h0010, 16'h0010, 4'd9, 10'd16);
    wait_result(bc);
    chk("int_mul_lit", 32'(result), 32'h0000);
    chk("int_mul_cout", 32'(cout), 32'd1);

    send(3'd3, 1'b1, 16'h1234, 16'hFFFF, 4'd10, 10'd17);
    send(3'd5, 1'b0, 16'h0056, 16'h0011, 4'd11, 10'd18);
    @(negedge clk);
    chk("pass_reserved_lit", 32'(result), 32'h0056);

    // Backpressure, then release straight into a 1/cycle stream
    send(3'd0, 1'b1, 16'h0102, 16'h0304, 4'd12, 10'd19);
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd0; rns_op = 1'b1; op1 = 16'h0506; op2 = 16'h0708;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result_hold", 32'(result), 32'h0406);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    c0 = cyc;
    send(3'd0, 1'b1, 16'h0506, 16'h0708, 4'd13, 10'd20);
    send(3'd0, 1'b1, 16'h1010, 16'h2020, 4'd14, 10'd21);
    send(3'd0, 1'b1, 16'h7F7F, 16'h0101, 4'd15, 10'd22);
    send(3'd0, 1'b1, 16'hFF80, 16'h0202, 4'd1, 10'd23);
    chk("stream_cycles", 32'(cyc - c0), 32'd4);
    @(negedge clk);
    chk("stream_last_lit", 32'(result), 32'h0101);

    // Flush on the 4th busy cycle with an ADD presented
    send(3'd2, 1'b1, 16'hC864, 16'h6432, 4'd2, 10'd24);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1; op = 3'd0; rns_op = 1'b1; op1 = 16'h0101; op2 = 16'h0101;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    count_valid(12, vc);
    chk("flush_no_result", 32'(vc), 32'd0);

    // Reset held for two cycles in the middle of a multiply
    send(3'd2, 1'b1, 16'hC864, 16'h6432, 4'd3, 10'd25);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_pc_out", 32'(pc_out), 32'd0);
    count_valid(12, vc);
    chk("rst_no_result", 32'(vc), 32'd0);

    send(3'd0, 1'b1, 16'hC864, 16'h6432, 4'd4, 10'd26);
    @(negedge clk);
    chk("post_reset_add", 32'(result), 32'h2C15);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
